alu_operand_fetch: RTL and testbench

//  Operand-fetch stage directly upstream of the ALU. Holds the 8x16 register file.

---
 rtl/alu_operand_fetch.sv | 93 +++++++++
 tb/tb_alu_operand_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage ahead of the ALU: register file with write bypass, B-path shifter,
// asel/bsel source selects, and a single valid/ready output register slice.
module alu_operand_fetch #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [1:0]        shift,
  input  logic              asel,
  input  logic              bsel,
  input  logic [DATA_W-1:0] sximm,
  input  logic [1:0]        alu_op_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Ain,
  output logic [DATA_W-1:0] Bin,
  output logic [1:0]        ALUop
);

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  logic signed [DATA_W-1:0] regs [NREGS];
  logic signed [DATA_W-1:0] rd_n, rd_m;
  logic signed [DATA_W-1:0] a_nxt, b_nxt;
  logic signed [DATA_W-1:0] a_p0, b_p0;
  logic        [1:0]        op_p0;
  logic                     vld_p0;
  logic                     accept;

  // One-bit shifts keep DATA_W; the shifted-out bit is discarded.
  function automatic logic signed [DATA_W-1:0] bshift(
    input logic signed [DATA_W-1:0] v,
    input logic        [1:0]        sh
  );
    case (sh)
      SH_NONE: bshift = v;
      SH_LSL:  bshift = v <<< 1;
      SH_LSR:  bshift = $signed({1'b0, v[DATA_W-1:1]});
      SH_ASR:  bshift = v >>> 1;
      default: bshift = v;
    endcase
  endfunction

  // Slice accepts whenever it is empty or being drained; held low while in reset.
  assign in_ready = ~reset & (~vld_p0 | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    rd_n  = (wr_en && (wr_addr == rn)) ? $signed(wr_data) : regs[rn];
    rd_m  = (wr_en && (wr_addr == rm)) ? $signed(wr_data) : regs[rm];
    a_nxt = asel ? '0 : rd_n;
    b_nxt = bsel ? $signed(sximm) : bshift(rd_m, shift);
  end

  // Stage p0: operands captured at accept; register file written independently
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      op_p0  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wr_en) regs[wr_addr] <= $signed(wr_data);
      if (accept) begin
        vld_p0 <= 1'b1;
        a_p0   <= a_nxt;
        b_p0   <= b_nxt;
        op_p0  <= alu_op_in;
      end else if (out_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p0;
  assign Ain       = $unsigned(a_p0);
  assign Bin       = $unsigned(b_p0);
  assign ALUop     = op_p0;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Scoreboard bench for alu_operand_fetch: driver pushes hand-computed results on accept,
// monitor pops and compares each output the ALU side consumes.
module tb_alu_operand_fetch;
  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rn, rm;
  logic [1:0]        shift;
  logic              asel, bsel;
  logic [DATA_W-1:0] sximm;
  logic [1:0]        alu_op_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] Ain, Bin;
  logic [1:0]        ALUop;

  alu_operand_fetch #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rn(rn), .rm(rm), .shift(shift), .asel(asel), .bsel(bsel), .sximm(sximm),
    .alu_op_in(alu_op_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .Ain(Ain), .Bin(Bin), .ALUop(ALUop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        op;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the coming edge whenever out_valid & out_ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got Ain=0x%0h Bin=0x%0h with no op expected", Ain, Bin);
      end else begin
        mon_e = q.pop_front();
        check("Ain", 32'(Ain), 32'(mon_e.a));
        check("Bin", 32'(Bin), 32'(mon_e.b));
        check("ALUop", 32'(ALUop), 32'(mon_e.op));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] n, input logic [ADDR_W-1:0] m,
                       input logic [1:0] sh, input logic as, input logic bs,
                       input logic [DATA_W-1:0] imm, input logic [1:0] op,
                       input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
    int w;
    w = 0;
    rn = n; rm = m; shift = sh; asel = as; bsel = bs; sximm = imm; alu_op_in = op;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, w);
    end
    @(posedge clk);
    #1;
    if (w < 20) q.push_back({ea, eb, op});
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    reset = 1'b1; in_valid = 1'b0; rn = '0; rm = '0; shift = '0; asel = 1'b0;
    bsel = 1'b0; sximm = '0; alu_op_in = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; out_ready = 1'b1;
    cyc();
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_Ain", 32'(Ain), 32'd0);
    check("rst_Bin", 32'(Bin), 32'd0);
    check("rst_ALUop", 32'(ALUop), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    cyc();

    // Basic ADD operand fetch with one-cycle latency
    write_reg(3'd1, 16'h0005);
    write_reg(3'd2, 16'h0003);
    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0005, 16'h0003);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    cyc();

    // Shifter paths on 0x8001
    write_reg(3'd3, 16'h8001);
    issue(3'd0, 3'd3, 2'b11, 1'b0, 1'b0, 16'h0000, 2'b01, 16'h0000, 16'hC000);
    issue(3'd0, 3'd3, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b01, 16'h0000, 16'h4000);
    issue(3'd0, 3'd3, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b01, 16'h0000, 16'h0002);
    issue(3'd3, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b10, 16'h8001, 16'h8001);

    // Same-cycle write bypass
    write_reg(3'd4, 16'h1111);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hBEEF;
    issue(3'd4, 3'd4, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b10, 16'hBEEF, 16'hBEEF);
    wr_en = 1'b0;
    issue(3'd4, 3'd4, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'hBEEF, 16'hBEEF);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    issue(3'd4, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'hBEEF, 16'h1234);
    wr_en = 1'b0;
    cyc();

    // Backpressure: A held while B waits and A's sources are overwritten
    out_ready = 1'b0;
    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0005, 16'h0003);
    rn = 3'd3; rm = 3'd4; shift = 2'b00; asel = 1'b0; bsel = 1'b0; alu_op_in = 2'b11;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = (i < 2); wr_addr = (i == 0) ? 3'd1 : 3'd2;
      wr_data = (i == 0) ? 16'h7777 : 16'h6666;
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_Ain", 32'(Ain), 32'h0005);
      check("stall_Bin", 32'(Bin), 32'h0003);
      cyc();
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    q.push_back({16'h8001, 16'hBEEF, 2'b11});
    in_valid = 1'b0;
    cyc();
    @(negedge clk);
    check("drained_out_valid", 32'(out_valid), 32'd0);
    check("drained_queue", 32'(q.size()), 32'd0);
    cyc();
    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h7777, 16'h6666);

    // Source selects override register/shift paths
    issue(3'd1, 3'd2, 2'b11, 1'b1, 1'b1, 16'hFFF0, 2'b00, 16'h0000, 16'hFFF0);
    issue(3'd7, 3'd3, 2'b01, 1'b1, 1'b1, 16'h8000, 2'b01, 16'h0000, 16'h8000);
    issue(3'd1, 3'd3, 2'b00, 1'b1, 1'b0, 16'h5555, 2'b10, 16'h0000, 16'h8001);
    issue(3'd2, 3'd3, 2'b10, 1'b0, 1'b1, 16'h00A5, 2'b11, 16'h6666, 16'h00A5);
    cyc();

    // Reset while holding an op and writing
    out_ready = 1'b0;
    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 16'h7777, 16'h6666);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hAAAA;
    reset = 1'b1;
    @(negedge clk);
    check("in_ready_in_reset2", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; wr_en = 1'b0;
    q.delete();
    @(negedge clk);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_Ain", 32'(Ain), 32'd0);
    check("rst2_Bin", 32'(Bin), 32'd0);
    check("rst2_ALUop", 32'(ALUop), 32'd0);
    cyc();
    out_ready = 1'b1;
    for (int r = 0; r < NREGS; r += 2) begin
      issue(ADDR_W'(r), ADDR_W'(r + 1), 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'h0000);
    end

    w = 0;
    while (q.size() != 0 && w < 20) begin
      w++;
      cyc();
    end
    cyc();
    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
